cirno9_mem_arb: RTL and testbench

//  Shares the single SRAM port between three requesters: instruction fetch (f_), load/store from the EXU (d_), and an

---
 rtl/cirno9_mem_arb.sv | 158 +++++++++++++++
 tb/tb_cirno9_mem_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cirno9_mem_arb.sv
// Three-way arbiter (fetch, data, external) sharing one SRAM port, one access in flight at a time.
// The winning command is registered and held until the SRAM returns ready or the watchdog expires.
module cirno9_mem_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_val,
  input  logic [31:0] f_adr,
  output logic        f_rdy,
  input  logic        d_val,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdat,
  input  logic [3:0]  d_wen,
  input  logic        d_ren,
  output logic        d_rdy,
  input  logic        x_val,
  input  logic [31:0] x_adr,
  input  logic [31:0] x_wdat,
  input  logic [3:0]  x_wen,
  input  logic        x_ren,
  output logic        x_rdy,
  output logic [31:0] o_rdat,
  output logic        o_sram_ren,
  output logic [3:0]  o_sram_wen,
  output logic [31:0] o_adr,
  output logic [31:0] o_wdat,
  input  logic [31:0] i_sram_rdat,
  input  logic        i_ram_rdy,
  output logic [1:0]  o_gnt,
  output logic        o_err
);

  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);
  localparam logic [15:0] WdLast    = 16'(TIMEOUT - 1);
  localparam bit          WdEn      = (TIMEOUT != 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  wen_q, wen_d;
  logic        ren_q, ren_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] wd_q, wd_d;

  logic       busy, null_cmd, timeout, done, arb_en;
  logic       fv, dv, xv;
  logic [1:0] win;

  assign busy     = (state_q == StBusy);
  assign null_cmd = (wen_q == 4'h0) && !ren_q;
  assign timeout  = busy && WdEn && !null_cmd && !i_ram_rdy && (wd_q == WdLast);
  assign done     = busy && (null_cmd || i_ram_rdy || timeout);
  assign arb_en   = !busy || done;

  // The requester completing this cycle may not win the back-to-back slot.
  assign fv = f_val && !(done && gnt_q == 2'd1);
  assign dv = d_val && !(done && gnt_q == 2'd2);
  assign xv = x_val && !(done && gnt_q == 2'd3);

  always_comb begin
    win = 2'd0;
    if (fv && starve_q == StarveMax) win = 2'd1;
    else if (dv)                     win = 2'd2;
    else if (xv)                     win = 2'd3;
    else if (fv)                     win = 2'd1;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    wen_d    = wen_q;
    ren_d    = ren_q;
    starve_d = starve_q;
    wd_d     = wd_q;
    if (busy && !done) wd_d = wd_q + 16'd1;
    if (arb_en) begin
      if (win == 2'd1) begin
        starve_d = 4'd0;
      end else if (fv && win != 2'd0 && starve_q != StarveMax) begin
        starve_d = starve_q + 4'd1;
      end
      gnt_d = win;
      wd_d  = 16'd0;
      // Command registers are zeroed whenever idle so the SRAM pins rest at 0.
      case (win)
        2'd1: begin
          state_d = StBusy;
          adr_d   = f_adr;
          wdat_d  = 32'd0;
          wen_d   = 4'h0;
          ren_d   = 1'b1;
        end
        2'd2: begin
          state_d = StBusy;
          adr_d   = d_adr;
          wdat_d  = d_wdat;
          wen_d   = d_wen;
          ren_d   = d_ren;
        end
        2'd3: begin
          state_d = StBusy;
          adr_d   = x_adr;
          wdat_d  = x_wdat;
          wen_d   = x_wen;
          ren_d   = x_ren;
        end
        default: begin
          state_d = StIdle;
          adr_d   = 32'd0;
          wdat_d  = 32'd0;
          wen_d   = 4'h0;
          ren_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= 2'd0;
      adr_q    <= 32'd0;
      wdat_q   <= 32'd0;
      wen_q    <= 4'h0;
      ren_q    <= 1'b0;
      starve_q <= 4'd0;
      wd_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_adr      = adr_q;
  assign o_wdat     = wdat_q;
  assign o_sram_wen = wen_q;
  assign o_sram_ren = ren_q;
  assign f_rdy      = done && (gnt_q == 2'd1);
  assign d_rdy      = done && (gnt_q == 2'd2);
  assign x_rdy      = done && (gnt_q == 2'd3);
  assign o_rdat     = (done && i_ram_rdy && !null_cmd) ? i_sram_rdat : 32'd0;
  assign o_err      = timeout;

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Bench for cirno9_mem_arb: directed scenarios plus random traffic, every cycle compared
// against a transaction-level reference model.
module tb_cirno9_mem_arb;

  localparam int SM = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_val, d_val, x_val, d_ren, x_ren, i_ram_rdy;
  logic [31:0] f_adr, d_adr, d_wdat, x_adr, x_wdat, i_sram_rdat;
  logic [3:0]  d_wen, x_wen;
  logic        f_rdy, d_rdy, x_rdy, o_sram_ren, o_err;
  logic [31:0] o_rdat, o_adr, o_wdat;
  logic [3:0]  o_sram_wen;
  logic [1:0]  o_gnt;

  always #5 clk = ~clk;

  cirno9_mem_arb #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .f_val(f_val), .f_adr(f_adr), .f_rdy(f_rdy),
    .d_val(d_val), .d_adr(d_adr), .d_wdat(d_wdat), .d_wen(d_wen), .d_ren(d_ren), .d_rdy(d_rdy),
    .x_val(x_val), .x_adr(x_adr), .x_wdat(x_wdat), .x_wen(x_wen), .x_ren(x_ren), .x_rdy(x_rdy),
    .o_rdat(o_rdat), .o_sram_ren(o_sram_ren), .o_sram_wen(o_sram_wen), .o_adr(o_adr),
    .o_wdat(o_wdat), .i_sram_rdat(i_sram_rdat), .i_ram_rdy(i_ram_rdy), .o_gnt(o_gnt),
    .o_err(o_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner id (0 none, 1 f, 2 d, 3 x), held command, fetch losses, cycles spent.
  int          m_owner, n_owner, m_loss, n_loss, m_age, n_age;
  logic [31:0] m_adr, n_adr, m_wdat, n_wdat;
  logic [3:0]  m_wen, n_wen;
  logic        m_ren, n_ren;
  logic [2:0]  e_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_loss = 0; m_age = 0; m_adr = '0; m_wdat = '0; m_wen = '0; m_ren = 1'b0;
    n_owner = 0; n_loss = 0; n_age = 0; n_adr = '0; n_wdat = '0; n_wen = '0; n_ren = 1'b0;
    e_rdy = '0;
  endtask

  task automatic compare_all(input logic [2:0] rdy, input logic [31:0] rdat, input bit err);
    check("rdy", 32'({x_rdy, d_rdy, f_rdy}), 32'(rdy));
    check("gnt", 32'(o_gnt), 32'(m_owner));
    check("err", 32'(o_err), 32'(err));
    check("rdat", o_rdat, rdat);
    check("ren", 32'(o_sram_ren), 32'(m_ren));
    check("wen", 32'(o_sram_wen), 32'(m_wen));
    check("adr", o_adr, m_adr);
    check("wdat", o_wdat, m_wdat);
  endtask

  task automatic eval();
    bit          busy, nul, to_hit, fin, arb;
    bit          want[4];
    int          order[3];
    int          win;
    logic [31:0] e_rdat;
    @(negedge clk);
    if (rst) begin
      model_reset();
      compare_all(3'b000, 32'd0, 1'b0);
      return;
    end
    busy   = (m_owner != 0);
    nul    = (m_wen == 4'h0) && !m_ren;
    to_hit = busy && !nul && !i_ram_rdy && (TO != 0) && (m_age + 1 == TO);
    fin    = busy && (nul || i_ram_rdy || to_hit);
    e_rdy  = '0;
    if (fin) e_rdy[m_owner-1] = 1'b1;
    e_rdat = (fin && i_ram_rdy && !nul) ? i_sram_rdat : 32'd0;
    compare_all(e_rdy, e_rdat, to_hit);
    n_owner = m_owner; n_loss = m_loss; n_age = m_age + 1;
    n_adr = m_adr; n_wdat = m_wdat; n_wen = m_wen; n_ren = m_ren;
    arb = !busy || fin;
    if (arb) begin
      want[0] = 1'b0; want[1] = f_val; want[2] = d_val; want[3] = x_val;
      if (fin) want[m_owner] = 1'b0;
      order = '{2, 3, 1};
      win = 0;
      if (want[1] && m_loss == SM) win = 1;
      else for (int k = 0; k < 3; k++) if (win == 0 && want[order[k]]) win = order[k];
      if (win == 1) n_loss = 0;
      else if (win != 0 && want[1]) n_loss = (m_loss + 1 > SM) ? SM : m_loss + 1;
      n_owner = win;
      n_age = 0;
      case (win)
        1: begin n_adr = f_adr; n_wdat = '0;     n_wen = '0;    n_ren = 1'b1;  end
        2: begin n_adr = d_adr; n_wdat = d_wdat; n_wen = d_wen; n_ren = d_ren; end
        3: begin n_adr = x_adr; n_wdat = x_wdat; n_wen = x_wen; n_ren = x_ren; end
        default: begin n_adr = '0; n_wdat = '0; n_wen = '0; n_ren = 1'b0; end
      endcase
    end
  endtask

  task automatic adv();
    @(posedge clk);
    m_owner = n_owner; m_loss = n_loss; m_age = n_age;
    m_adr = n_adr; m_wdat = n_wdat; m_wen = n_wen; m_ren = n_ren;
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  int exp_seq[6];
  int rdy_cnt;
  int pct;

  initial begin
    rst = 1'b1;
    f_val = 0; d_val = 0; x_val = 0; d_ren = 0; x_ren = 0; i_ram_rdy = 0;
    f_adr = '0; d_adr = '0; d_wdat = '0; x_adr = '0; x_wdat = '0; d_wen = '0; x_wen = '0;
    i_sram_rdat = '0;
    model_reset();
    step();
    rst = 1'b0;

    // Single fetch, zero wait states
    f_val = 1; f_adr = 32'h100; i_ram_rdy = 1; i_sram_rdat = 32'hCAFE0001;
    eval(); check("fetch_idle_gnt", 32'(o_gnt), 32'd0); adv();
    eval();
    check("fetch_adr", o_adr, 32'h100);
    check("fetch_ren", 32'(o_sram_ren), 32'd1);
    check("fetch_rdy", 32'(f_rdy), 32'd1);
    check("fetch_rdat", o_rdat, 32'hCAFE0001);
    adv(); f_val = 0;
    step();

    // Contention: d, then x, then f, back-to-back
    f_val = 1; f_adr = 32'h300;
    d_val = 1; d_adr = 32'h200; d_wdat = 32'hDEADBEEF; d_wen = 4'hF; d_ren = 0;
    x_val = 1; x_adr = 32'h400; x_wdat = 32'h0; x_wen = 4'h0; x_ren = 1;
    step();
    eval();
    check("cont_gnt_d", 32'(o_gnt), 32'd2);
    check("cont_wen_d", 32'(o_sram_wen), 32'hF);
    check("cont_wdat_d", o_wdat, 32'hDEADBEEF);
    adv(); d_val = 0;
    eval(); check("cont_gnt_x", 32'(o_gnt), 32'd3); check("cont_wen_x", 32'(o_sram_wen), 32'd0);
    adv(); x_val = 0;
    eval(); check("cont_gnt_f", 32'(o_gnt), 32'd1); adv(); f_val = 0;
    eval(); check("cont_idle", 32'(o_gnt), 32'd0); adv();

    // Starvation: d and x alternate until fetch is forced in on the 5th arbitration
    f_val = 1; f_adr = 32'h900;
    d_val = 1; d_adr = 32'hA00; d_wen = 4'h0; d_ren = 1;
    x_val = 1; x_adr = 32'hB00; x_wen = 4'h0; x_ren = 1;
    exp_seq = '{2, 3, 2, 3, 1, 2};
    step();
    for (int i = 0; i < 6; i++) begin
      eval(); check("starve_gnt", 32'(o_gnt), 32'(exp_seq[i])); adv();
      if (i == 4) f_val = 0;
    end
    d_val = 0; x_val = 0;
    repeat (3) step();

    // Wait states: three cycles without ready
    d_val = 1; d_adr = 32'h500; d_wen = 4'h0; d_ren = 1; i_ram_rdy = 0;
    step();
    rdy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      i_ram_rdy = (k == 3);
      eval();
      check("ws_adr", o_adr, 32'h500);
      check("ws_ren", 32'(o_sram_ren), 32'd1);
      rdy_cnt += int'(d_rdy);
      adv();
    end
    d_val = 0;
    check("ws_rdy_once", 32'(rdy_cnt), 32'd1);
    step();

    // Watchdog timeout with x pending
    d_val = 1; d_adr = 32'h600; d_wen = 4'h0; d_ren = 1;
    x_val = 1; x_adr = 32'h700; x_wen = 4'h0; x_ren = 1;
    i_ram_rdy = 0; i_sram_rdat = 32'h12345678;
    step();
    for (int k = 1; k <= 8; k++) begin
      eval();
      if (k < 8) check("to_early_rdy", 32'(d_rdy), 32'd0);
      else begin
        check("to_rdy", 32'(d_rdy), 32'd1);
        check("to_err", 32'(o_err), 32'd1);
        check("to_rdat", o_rdat, 32'd0);
      end
      adv();
    end
    d_val = 0;
    eval(); check("to_next_gnt", 32'(o_gnt), 32'd3); adv();
    i_ram_rdy = 1;
    step(); x_val = 0;
    step();

    // Reset during an access
    d_val = 1; d_adr = 32'h800; d_wen = 4'h3; d_ren = 1; i_ram_rdy = 0;
    step(); step();
    rst = 1'b1; #1;
    check("rst_ren", 32'(o_sram_ren), 32'd0);
    check("rst_wen", 32'(o_sram_wen), 32'd0);
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_rdy", 32'({x_rdy, d_rdy, f_rdy}), 32'd0);
    model_reset();
    step();
    rst = 1'b0; i_ram_rdy = 1;
    eval(); check("rerun_idle", 32'(o_gnt), 32'd0); adv();
    eval(); check("rerun_gnt", 32'(o_gnt), 32'd2); check("rerun_rdy", 32'(d_rdy), 32'd1); adv();
    d_val = 0;
    step();

    // Random traffic, later half with a slow SRAM to provoke timeouts
    for (int c = 0; c < 600; c++) begin
      if (e_rdy[0]) f_val = 0;
      if (e_rdy[1]) d_val = 0;
      if (e_rdy[2]) x_val = 0;
      if (!f_val && $urandom_range(0, 2) == 0) begin
        f_val = 1; f_adr = $urandom;
      end
      if (!d_val && $urandom_range(0, 2) == 0) begin
        d_val = 1; d_adr = $urandom; d_wdat = $urandom; d_ren = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: d_wen = 4'h0;
          1: d_wen = 4'hF;
          default: d_wen = 4'($urandom);
        endcase
      end
      if (!x_val && $urandom_range(0, 2) == 0) begin
        x_val = 1; x_adr = $urandom; x_wdat = $urandom; x_ren = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: x_wen = 4'h0;
          1: x_wen = 4'hF;
          default: x_wen = 4'($urandom);
        endcase
      end
      pct = (c < 300) ? 6 : 1;
      i_ram_rdy = ($urandom_range(0, 9) < pct);
      i_sram_rdat = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
